// File: rtl/eth_rx_tile_pkg.sv
// Shared types for the Ethernet RX tile: NoC output flit mux select and the
// NoC output control FSM state encoding.
package eth_rx_tile_pkg;

    // Datapath flit mux select for the NoC output path
    typedef enum logic [1:0] {
        SEL_HDR_FLIT  = 2'd0,
        SEL_META_FLIT = 2'd1,
        SEL_DATA_FLIT = 2'd2
    } noc_out_flit_mux_sel;

    // NoC output control FSM states
    typedef enum logic [2:0] {
        READY    = 3'd0,
        HDR_OUT  = 3'd1,
        META_OUT = 3'd2,
        DATA_OUT = 3'd3,
        DRAIN    = 3'd4
    } noc_out_ctrl_state;

endpackage

// File: rtl/eth_rx_noc_out_ctrl_if.sv
// Handshake bundle between the RX formatter, the NoC output control block and
// the noc0 router. The master side is the control block; the slave side is
// the surrounding formatter/NoC environment.
interface eth_rx_noc_out_ctrl_if;

    logic eth_format_eth_rx_out_rx_hdr_val;
    logic eth_rx_out_eth_format_rx_hdr_rdy;
    logic eth_format_eth_rx_out_data_val;
    logic eth_format_eth_rx_out_data_last;
    logic eth_rx_out_eth_format_data_rdy;
    logic eth_rx_out_noc0_vrtoc_val;
    logic noc0_vrtoc_eth_rx_out_rdy;

    modport master (
        input  eth_format_eth_rx_out_rx_hdr_val,
        output eth_rx_out_eth_format_rx_hdr_rdy,
        input  eth_format_eth_rx_out_data_val,
        input  eth_format_eth_rx_out_data_last,
        output eth_rx_out_eth_format_data_rdy,
        output eth_rx_out_noc0_vrtoc_val,
        input  noc0_vrtoc_eth_rx_out_rdy
    );

    modport slave (
        output eth_format_eth_rx_out_rx_hdr_val,
        input  eth_rx_out_eth_format_rx_hdr_rdy,
        output eth_format_eth_rx_out_data_val,
        output eth_format_eth_rx_out_data_last,
        input  eth_rx_out_eth_format_data_rdy,
        input  eth_rx_out_noc0_vrtoc_val,
        output noc0_vrtoc_eth_rx_out_rdy
    );

endinterface

// File: rtl/eth_rx_noc_out_ctrl.sv
// Ethernet RX NoC output control: accepts a parsed header, then sequences one
// header flit, one metadata flit and the frame's data flits onto noc0. Frames
// whose EtherType misses in the dispatch CAM are drained upstream and counted
// instead of being sent. Handshake outputs are combinational from state and
// inputs; state and the two saturating counters are the only registers.
module eth_rx_noc_out_ctrl
    import eth_rx_tile_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    eth_rx_noc_out_ctrl_if.master bus,
    output noc_out_flit_mux_sel ctrl_datap_flit_sel,
    output logic                ctrl_datap_store_inputs,
    input  logic                cam_ctrl_rd_hit,
    output logic [CNT_W-1:0]    eth_rx_out_fwd_cnt,
    output logic [CNT_W-1:0]    eth_rx_out_drop_cnt
);

    noc_out_ctrl_state state_q;
    logic [CNT_W-1:0]  fwd_cnt_q;
    logic [CNT_W-1:0]  drop_cnt_q;

    // Saturating increment: holds at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Decode handshakes and datapath controls; everything is quiet while rst is high
    always_comb begin
        bus.eth_rx_out_eth_format_rx_hdr_rdy = 1'b0;
        bus.eth_rx_out_eth_format_data_rdy   = 1'b0;
        bus.eth_rx_out_noc0_vrtoc_val        = 1'b0;
        ctrl_datap_store_inputs              = 1'b0;
        ctrl_datap_flit_sel                  = SEL_HDR_FLIT;
        if (!rst) begin
            case (state_q)
                READY: begin
                    bus.eth_rx_out_eth_format_rx_hdr_rdy = 1'b1;
                    // Datapath bypasses the header onto the CAM tag on this strobe
                    ctrl_datap_store_inputs = bus.eth_format_eth_rx_out_rx_hdr_val;
                end
                HDR_OUT: begin
                    ctrl_datap_flit_sel           = SEL_HDR_FLIT;
                    bus.eth_rx_out_noc0_vrtoc_val = 1'b1;
                end
                META_OUT: begin
                    ctrl_datap_flit_sel           = SEL_META_FLIT;
                    bus.eth_rx_out_noc0_vrtoc_val = 1'b1;
                end
                DATA_OUT: begin
                    // Beats pass straight through; noc rdy never depends on val
                    ctrl_datap_flit_sel                = SEL_DATA_FLIT;
                    bus.eth_rx_out_noc0_vrtoc_val      = bus.eth_format_eth_rx_out_data_val;
                    bus.eth_rx_out_eth_format_data_rdy = bus.noc0_vrtoc_eth_rx_out_rdy;
                end
                DRAIN: begin
                    ctrl_datap_flit_sel                = SEL_DATA_FLIT;
                    bus.eth_rx_out_eth_format_data_rdy = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Advance the frame sequence and update the forwarded/dropped counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= READY;
            fwd_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            case (state_q)
                READY: begin
                    if (bus.eth_format_eth_rx_out_rx_hdr_val) begin
                        if (cam_ctrl_rd_hit) begin
                            state_q <= HDR_OUT;
                        end else begin
                            state_q    <= DRAIN;
                            drop_cnt_q <= sat_inc(drop_cnt_q);
                        end
                    end
                end
                HDR_OUT: begin
                    if (bus.noc0_vrtoc_eth_rx_out_rdy) state_q <= META_OUT;
                end
                META_OUT: begin
                    if (bus.noc0_vrtoc_eth_rx_out_rdy) state_q <= DATA_OUT;
                end
                DATA_OUT: begin
                    if (bus.eth_format_eth_rx_out_data_val && bus.noc0_vrtoc_eth_rx_out_rdy &&
                        bus.eth_format_eth_rx_out_data_last) begin
                        state_q   <= READY;
                        fwd_cnt_q <= sat_inc(fwd_cnt_q);
                    end
                end
                DRAIN: begin
                    if (bus.eth_format_eth_rx_out_data_val && bus.eth_format_eth_rx_out_data_last)
                        state_q <= READY;
                end
                default: state_q <= READY;
            endcase
        end
    end

    assign eth_rx_out_fwd_cnt  = fwd_cnt_q;
    assign eth_rx_out_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_noc_out_ctrl.sv
// Bench for the Ethernet RX NoC output control FSM. Expected flit selects are
// queued when a hit frame is driven and popped as noc0 accepts flits.
module tb_eth_rx_noc_out_ctrl;
    import eth_rx_tile_pkg::*;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                clk;
    logic                rst;
    logic                cam_hit;
    noc_out_flit_mux_sel sel;
    logic                store;
    logic [CNT_W-1:0]    fwd_cnt;
    logic [CNT_W-1:0]    drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    noc_out_flit_mux_sel sb[$];

    eth_rx_noc_out_ctrl_if ifc ();

    eth_rx_noc_out_ctrl #(.CNT_W(CNT_W)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .bus                     (ifc.master),
        .ctrl_datap_flit_sel     (sel),
        .ctrl_datap_store_inputs (store),
        .cam_ctrl_rd_hit         (cam_hit),
        .eth_rx_out_fwd_cnt      (fwd_cnt),
        .eth_rx_out_drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard: every accepted noc0 flit must match the next expected select
    always @(negedge clk) begin
        if (ifc.eth_rx_out_noc0_vrtoc_val && ifc.noc0_vrtoc_eth_rx_out_rdy) begin
            chk("sb_flit_expected", sb.size() != 0, 1);
            if (sb.size() != 0) chk("sb_flit_sel", sel, sb.pop_front());
        end
    end

    task automatic push_frame(input int nbeats);
        sb.push_back(SEL_HDR_FLIT);
        sb.push_back(SEL_META_FLIT);
        for (int i = 0; i < nbeats; i++) sb.push_back(SEL_DATA_FLIT);
    endtask

    task automatic send_hdr(input logic hit);
        int n = 0;
        ifc.eth_format_eth_rx_out_rx_hdr_val = 1'b1;
        cam_hit = hit;
        @(negedge clk);
        while (!ifc.eth_rx_out_eth_format_rx_hdr_rdy && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("hdr_accept_timeout", n < 50, 1);
        chk("hdr_store_inputs", store, 1);
        @(posedge clk);
        #1;
        ifc.eth_format_eth_rx_out_rx_hdr_val = 1'b0;
        cam_hit = ~hit;
    endtask

    task automatic send_beat(input logic last);
        int n = 0;
        ifc.eth_format_eth_rx_out_data_val  = 1'b1;
        ifc.eth_format_eth_rx_out_data_last = last;
        @(negedge clk);
        while (!ifc.eth_rx_out_eth_format_data_rdy && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("beat_accept_timeout", n < 50, 1);
        @(posedge clk);
        #1;
        ifc.eth_format_eth_rx_out_data_val  = 1'b0;
        ifc.eth_format_eth_rx_out_data_last = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        cam_hit = 1'b1;
        ifc.eth_format_eth_rx_out_rx_hdr_val = 1'b1;
        ifc.eth_format_eth_rx_out_data_val   = 1'b1;
        ifc.eth_format_eth_rx_out_data_last  = 1'b0;
        ifc.noc0_vrtoc_eth_rx_out_rdy        = 1'b1;

        // Reset: outputs quiet even with inputs active
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hdr_rdy", ifc.eth_rx_out_eth_format_rx_hdr_rdy, 0);
        chk("rst_data_rdy", ifc.eth_rx_out_eth_format_data_rdy, 0);
        chk("rst_noc_val", ifc.eth_rx_out_noc0_vrtoc_val, 0);
        chk("rst_store", store, 0);
        chk("rst_sel", sel, SEL_HDR_FLIT);
        chk("rst_fwd", fwd_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifc.eth_format_eth_rx_out_rx_hdr_val = 1'b0;
        ifc.eth_format_eth_rx_out_data_val   = 1'b0;
        @(negedge clk);
        chk("idle_hdr_rdy", ifc.eth_rx_out_eth_format_rx_hdr_rdy, 1);
        chk("idle_store", store, 0);
        @(posedge clk);
        #1;

        // Hit frame, 3 beats, noc rdy held high: flits at T+1..T+5, READY at T+6
        push_frame(3);
        send_hdr(1'b1);
        fork
            begin
                send_beat(1'b0);
                send_beat(1'b0);
                send_beat(1'b1);
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("t1_noc_val", ifc.eth_rx_out_noc0_vrtoc_val, 1);
                    chk("t1_sel", sel, (k == 0) ? SEL_HDR_FLIT : (k == 1) ? SEL_META_FLIT : SEL_DATA_FLIT);
                    if (k < 2) chk("t1_data_backpressure", ifc.eth_rx_out_eth_format_data_rdy, 0);
                end
                @(negedge clk);
                chk("t1_ready", ifc.eth_rx_out_eth_format_rx_hdr_rdy, 1);
                chk("t1_noc_val_idle", ifc.eth_rx_out_noc0_vrtoc_val, 0);
            end
        join
        chk("t1_fwd_cnt", fwd_cnt, 1);
        chk("t1_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;

        // CAM miss, 4 beats: drained, never on the NoC
        send_hdr(1'b0);
        fork
            begin
                send_beat(1'b0);
                send_beat(1'b0);
                send_beat(1'b0);
                send_beat(1'b1);
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("t2_data_rdy", ifc.eth_rx_out_eth_format_data_rdy, 1);
                    chk("t2_noc_val", ifc.eth_rx_out_noc0_vrtoc_val, 0);
                    chk("t2_hdr_rdy", ifc.eth_rx_out_eth_format_rx_hdr_rdy, 0);
                end
                @(negedge clk);
                chk("t2_ready", ifc.eth_rx_out_eth_format_rx_hdr_rdy, 1);
            end
        join
        chk("t2_drop_cnt", drop_cnt, 1);
        chk("t2_fwd_cnt", fwd_cnt, 1);
        @(posedge clk);
        #1;

        // NoC stall: 5 cycles on the header flit, 3 cycles on the 2nd data beat
        push_frame(2);
        ifc.noc0_vrtoc_eth_rx_out_rdy = 1'b0;
        send_hdr(1'b1);
        ifc.eth_format_eth_rx_out_data_val  = 1'b1;
        ifc.eth_format_eth_rx_out_data_last = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_hdr_stall_val", ifc.eth_rx_out_noc0_vrtoc_val, 1);
            chk("t3_hdr_stall_sel", sel, SEL_HDR_FLIT);
            chk("t3_hdr_stall_data_rdy", ifc.eth_rx_out_eth_format_data_rdy, 0);
            chk("t3_hdr_stall_hdr_rdy", ifc.eth_rx_out_eth_format_rx_hdr_rdy, 0);
            @(posedge clk);
            #1;
        end
        ifc.noc0_vrtoc_eth_rx_out_rdy = 1'b1;
        send_beat(1'b0);
        ifc.noc0_vrtoc_eth_rx_out_rdy       = 1'b0;
        ifc.eth_format_eth_rx_out_data_val  = 1'b1;
        ifc.eth_format_eth_rx_out_data_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_data_stall_val", ifc.eth_rx_out_noc0_vrtoc_val, 1);
            chk("t3_data_stall_sel", sel, SEL_DATA_FLIT);
            chk("t3_data_stall_data_rdy", ifc.eth_rx_out_eth_format_data_rdy, 0);
            @(posedge clk);
            #1;
        end
        ifc.noc0_vrtoc_eth_rx_out_rdy = 1'b1;
        send_beat(1'b1);
        @(negedge clk);
        chk("t3_ready", ifc.eth_rx_out_eth_format_rx_hdr_rdy, 1);
        chk("t3_fwd_cnt", fwd_cnt, 2);
        chk("t3_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;

        // Upstream bubble: data_val 1,0,0,1(last)
        push_frame(2);
        send_hdr(1'b1);
        send_beat(1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t4_bubble_noc_val", ifc.eth_rx_out_noc0_vrtoc_val, 0);
            chk("t4_bubble_hdr_rdy", ifc.eth_rx_out_eth_format_rx_hdr_rdy, 0);
            @(posedge clk);
            #1;
        end
        send_beat(1'b1);
        @(negedge clk);
        chk("t4_fwd_cnt", fwd_cnt, 3);
        chk("t4_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;

        // Reset after the meta flit: partial frame abandoned, counters cleared
        push_frame(1);
        send_hdr(1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("t5_pre_rst_sb", sb.size(), 1);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("t5_rst_noc_val", ifc.eth_rx_out_noc0_vrtoc_val, 0);
        chk("t5_rst_data_rdy", ifc.eth_rx_out_eth_format_data_rdy, 0);
        chk("t5_rst_sel", sel, SEL_HDR_FLIT);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_post_hdr_rdy", ifc.eth_rx_out_eth_format_rx_hdr_rdy, 1);
        chk("t5_post_fwd", fwd_cnt, 0);
        chk("t5_post_drop", drop_cnt, 0);
        @(posedge clk);
        #1;
        push_frame(2);
        send_hdr(1'b1);
        send_beat(1'b0);
        send_beat(1'b1);
        @(negedge clk);
        chk("t5_fwd_cnt", fwd_cnt, 1);
        chk("t5_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;

        // Saturation: drop counter reaches all-ones and stays there
        for (int i = 0; i < int'(CNT_MAX); i++) begin
            send_hdr(1'b0);
            send_beat(1'b1);
        end
        @(negedge clk);
        chk("t6_drop_at_max", drop_cnt, CNT_MAX);
        @(posedge clk);
        #1;
        send_hdr(1'b0);
        send_beat(1'b1);
        @(negedge clk);
        chk("t6_drop_saturated", drop_cnt, CNT_MAX);
        chk("t6_fwd_unchanged", fwd_cnt, 1);
        chk("final_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/eth_rx_noc_out_ctrl.md
Name: eth_rx_noc_out_ctrl

Overview:
- Control FSM that sequences the Ethernet RX NoC-output datapath.
- Accepts a parsed Ethernet header from the RX formatter, then emits one NoC header flit, one metadata flit and N data flits on noc0.
- Selects each flit through the datapath mux select and tells the datapath when to latch header and size.
- Frames whose EtherType misses in the dispatch CAM are drained and counted, never sent to the NoC.

Parameters:
- CNT_W, 32, width of the saturating forwarded-frame and dropped-frame counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- eth_format_eth_rx_out_rx_hdr_val  in  1  header/size valid from formatter
- eth_rx_out_eth_format_rx_hdr_rdy  out  1  header accepted
- eth_format_eth_rx_out_data_val  in  1  data beat valid
- eth_format_eth_rx_out_data_last  in  1  final data beat of frame
- eth_rx_out_eth_format_data_rdy  out  1  data beat accepted
- eth_rx_out_noc0_vrtoc_val  out  1  NoC flit valid
- noc0_vrtoc_eth_rx_out_rdy  in  1  NoC flit accepted
- ctrl_datap_flit_sel  out  noc_out_flit_mux_sel  flit mux select
- ctrl_datap_store_inputs  out  1  datapath latches header and size this cycle
- cam_ctrl_rd_hit  in  1  CAM hit for the current tag; combinational from the datapath tag
- eth_rx_out_fwd_cnt  out  CNT_W  frames forwarded
- eth_rx_out_drop_cnt  out  CNT_W  frames dropped on CAM miss

Behaviour:
- Reset: rst, synchronous, active-high; clock clk.
- While rst is high: all val/rdy outputs are 0, store_inputs is 0, sel is SEL_HDR_FLIT, both counters are 0 and state is READY.
- Handshakes: a transfer occurs on val&rdy in the same cycle. Outputs are combinational from state and inputs.
- READY:
  - hdr_rdy=1; store_inputs=hdr_val; noc_val=0; data_rdy=0.
  - hdr_val&hit -> HDR_OUT.
  - hdr_val&!hit -> DRAIN and drop_cnt increments.
  - The hit signal is sampled only in this cycle; the CAM tag reflects the incoming header because the datapath bypasses on store_inputs.
- HDR_OUT:
  - sel=SEL_HDR_FLIT; noc_val=1; hdr_rdy=0; data_rdy=0.
  - noc_rdy -> META_OUT; otherwise hold with all outputs stable.
- META_OUT:
  - sel=SEL_META_FLIT; noc_val=1.
  - noc_rdy -> DATA_OUT.
- DATA_OUT:
  - sel=SEL_DATA_FLIT; noc_val=data_val; data_rdy=noc_rdy (pass-through; no combinational loop, since noc_rdy is independent of val).
  - data_val&noc_rdy&last -> READY and fwd_cnt increments.
  - Non-last beats stay in DATA_OUT.
- DRAIN:
  - data_rdy=1; noc_val=0; sel=SEL_DATA_FLIT.
  - data_val&last -> READY.
- Counters saturate at all-ones and never wrap.
- Latency: header accepted at cycle T gives the header flit valid at T+1, earliest meta at T+2, earliest first data at T+3.
- Throughput: a frame of N data beats takes N+3 cycles minimum. The next header is accepted the cycle after the last beat, never in the same cycle.
- Boundaries:
  - The formatter guarantees at least 1 data beat per frame; a frame with zero beats is unsupported.
  - Data beats arriving while in READY/HDR_OUT/META_OUT are back-pressured (data_rdy=0).
  - NoC stalls of any length in any output state hold state and outputs.
  - hdr_val in any state other than READY is ignored; hdr_rdy=0.
  - rst asserted mid-frame returns to READY next cycle. The partial frame is abandoned and not counted; upstream and the NoC are reset together.

Decomposition:
- eth_rx_tile_pkg:
  - noc_out_flit_mux_sel enum with SEL_HDR_FLIT, SEL_META_FLIT, SEL_DATA_FLIT.
  - State enum noc_out_ctrl_state with READY, HDR_OUT, META_OUT, DATA_OUT, DRAIN.
- No sub-module; counters are inline. The block is instantiated beside the datapath in the eth RX tile top.

Test Plan:
- Hit frame, 3 beats, noc_rdy held 1: hdr accepted at T; val high T+1..T+5 with sel HDR,META,DATA,DATA,DATA; READY at T+6; fwd_cnt=1.
- CAM miss, 4 beats, data_val held 1: data_rdy=1 for 4 cycles; noc_val never asserted; drop_cnt=1; fwd_cnt=0; hdr_rdy=1 after last.
- NoC stall: noc_rdy=0 for 5 cycles in HDR_OUT, then 3 cycles on the 2nd data beat: sel and val stable throughout; data_rdy=0 during the stall; all 1+1+2 flits delivered in order.
- Upstream bubble: data_val toggles 1,0,0,1(last) in DATA_OUT: noc_val mirrors data_val; exactly 2 data flits delivered.
- Reset mid-frame: rst for 1 cycle after the meta flit: state READY; counters 0; next hit frame forwards normally with fwd_cnt=1.
- Saturation: preload drop_cnt to 2^CNT_W-1 via force, then one miss frame: count stays all-ones.
